// File: rtl/time_set_module_pkg.sv
// Shared definitions for the time-set editor: field layout, wrap limits,
// state encoding (doubles as the Mode code) and the field increment helper.
package time_set_module_pkg;

  localparam int TIME_W    = 15;
  localparam int DAY_LSB   = 12;
  localparam int DAY_W     = 3;
  localparam int HOUR_LSB  = 7;
  localparam int HOUR_W    = 5;
  localparam int MTENS_LSB = 4;
  localparam int MTENS_W   = 3;
  localparam int MONES_LSB = 0;
  localparam int MONES_W   = 4;

  localparam int MTENS_MAX = 5;
  localparam int MONES_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DAY    = 3'd1,
    ST_HOUR   = 3'd2,
    ST_MTENS  = 3'd3,
    ST_MONES  = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  // Advance only the field selected by the edit state. Anything at or above
  // its limit (including out-of-range captured values) wraps to zero.
  function automatic logic [TIME_W-1:0] bump_field(
    input logic [TIME_W-1:0] t,
    input state_t            field,
    input int                day_max,
    input int                hour_max
  );
    logic [TIME_W-1:0] r;
    r = t;
    case (field)
      ST_DAY:
        r[DAY_LSB +: DAY_W] = (int'(t[DAY_LSB +: DAY_W]) >= day_max)
                            ? '0 : t[DAY_LSB +: DAY_W] + DAY_W'(1);
      ST_HOUR:
        r[HOUR_LSB +: HOUR_W] = (int'(t[HOUR_LSB +: HOUR_W]) >= hour_max)
                              ? '0 : t[HOUR_LSB +: HOUR_W] + HOUR_W'(1);
      ST_MTENS:
        r[MTENS_LSB +: MTENS_W] = (int'(t[MTENS_LSB +: MTENS_W]) >= MTENS_MAX)
                                ? '0 : t[MTENS_LSB +: MTENS_W] + MTENS_W'(1);
      ST_MONES:
        r[MONES_LSB +: MONES_W] = (int'(t[MONES_LSB +: MONES_W]) >= MONES_MAX)
                                ? '0 : t[MONES_LSB +: MONES_W] + MONES_W'(1);
      default: r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_set_module_button_edge.sv
// Rising-edge detector for one debounced button, gated by Enable so that
// edges seen while disabled are discarded rather than queued.
module button_edge_module (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn,
  output logic press
);

  logic prev;

  // NOTE: prev resets to 1 so a button already held when reset is released
  // must be let go and pressed again before it counts.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prev <= 1'b1;
    else if (enable) prev <= btn;
  end

  assign press = enable & btn & ~prev;

endmodule

// File: rtl/time_set_module.sv
// Time-set editor: captures CTO, steps through day/hour/minute fields with
// Set, increments with Inc, and commits to current_time_module via one LD pulse.
module time_set_module
  import time_set_module_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DAY_MAX        = 6,
  parameter int HOUR_MAX       = 23
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Enable,
  input  logic              Set_Btn,
  input  logic              Inc_Btn,
  input  logic              Cancel_Btn,
  input  logic [TIME_W-1:0] CTO,
  output logic [TIME_W-1:0] CTI,
  output logic              LD,
  output logic [2:0]        Mode,
  output logic              Editing
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state;
  logic [CNT_W-1:0] idle_cnt;
  logic             set_press;
  logic             inc_press;
  logic             cancel_press;

  button_edge_module u_set_edge (
    .clk    (Clock),
    .rst_n  (Clear),
    .enable (Enable),
    .btn    (Set_Btn),
    .press  (set_press)
  );

  button_edge_module u_inc_edge (
    .clk    (Clock),
    .rst_n  (Clear),
    .enable (Enable),
    .btn    (Inc_Btn),
    .press  (inc_press)
  );

  button_edge_module u_cancel_edge (
    .clk    (Clock),
    .rst_n  (Clear),
    .enable (Enable),
    .btn    (Cancel_Btn),
    .press  (cancel_press)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= ST_IDLE;
      CTI      <= '0;
      LD       <= 1'b0;
      Editing  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      LD <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (set_press) begin
            CTI      <= CTO;
            state    <= ST_DAY;
            Editing  <= 1'b1;
            idle_cnt <= '0;
          end
        end

        ST_DAY, ST_HOUR, ST_MTENS, ST_MONES: begin
          // Presses are already gated by Enable; this gate freezes the counter.
          if (Enable) begin
            if (cancel_press) begin
              state   <= ST_IDLE;
              Editing <= 1'b0;
            end else if (set_press) begin
              idle_cnt <= '0;
              case (state)
                ST_DAY:   state <= ST_HOUR;
                ST_HOUR:  state <= ST_MTENS;
                ST_MTENS: state <= ST_MONES;
                default: begin
                  state   <= ST_COMMIT;
                  LD      <= 1'b1;
                  Editing <= 1'b0;
                end
              endcase
            end else if (inc_press) begin
              CTI      <= bump_field(CTI, state, DAY_MAX, HOUR_MAX);
              idle_cnt <= '0;
            end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              state   <= ST_IDLE;
              Editing <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end

        // Commit completes even with Enable low so LD is never left pending.
        ST_COMMIT: state <= ST_IDLE;

        default: begin
          state   <= ST_IDLE;
          Editing <= 1'b0;
        end
      endcase
    end
  end

  assign Mode = state;

endmodule

// File: tb/tb_time_set_module.sv
// Directed bench for time_set_module: a field-level behavioural model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_time_set_module;

  localparam int TIMEOUT = 64;
  localparam int DMAX    = 6;
  localparam int HMAX    = 23;

  logic        clk = 1'b0;
  logic        Clear;
  logic        Enable;
  logic        Set_Btn;
  logic        Inc_Btn;
  logic        Cancel_Btn;
  logic [14:0] CTO;
  logic [14:0] CTI;
  logic        LD;
  logic [2:0]  Mode;
  logic        Editing;

  int n_total = 0;
  int n_pass  = 0;
  int ld_count = 0;

  // Model state: mode number and the four time fields as plain integers.
  int m_mode = 0;
  int m_day = 0, m_hour = 0, m_tens = 0, m_ones = 0;
  int m_idle = 0;
  bit m_ld = 0;
  bit h_set = 1, h_inc = 1, h_can = 1;

  time_set_module #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .DAY_MAX        (DMAX),
    .HOUR_MAX       (HMAX)
  ) dut (
    .Clock      (clk),
    .Clear      (Clear),
    .Enable     (Enable),
    .Set_Btn    (Set_Btn),
    .Inc_Btn    (Inc_Btn),
    .Cancel_Btn (Cancel_Btn),
    .CTO        (CTO),
    .CTI        (CTI),
    .LD         (LD),
    .Mode       (Mode),
    .Editing    (Editing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int wrap_inc(input int v, input int max);
    return (v >= max) ? 0 : v + 1;
  endfunction

  function automatic logic [14:0] model_time();
    return 15'((m_day << 12) | (m_hour << 7) | (m_tens << 4) | m_ones);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_day = 0; m_hour = 0; m_tens = 0; m_ones = 0;
    m_idle = 0; m_ld = 0; h_set = 1; h_inc = 1; h_can = 1;
  endtask

  task automatic model_step();
    bit en, ps, pi, pc;
    en = Enable;
    ps = en && Set_Btn && !h_set;
    pi = en && Inc_Btn && !h_inc;
    pc = en && Cancel_Btn && !h_can;
    if (en) begin
      h_set = Set_Btn; h_inc = Inc_Btn; h_can = Cancel_Btn;
    end
    m_ld = 0;
    if (m_mode == 5) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (ps) begin
        m_day = CTO[14:12]; m_hour = CTO[11:7]; m_tens = CTO[6:4]; m_ones = CTO[3:0];
        m_mode = 1;
        m_idle = 0;
      end
    end else if (en) begin
      if (pc) begin
        m_mode = 0;
      end else if (ps) begin
        m_mode = m_mode + 1;
        m_idle = 0;
        if (m_mode == 5) m_ld = 1;
      end else if (pi) begin
        case (m_mode)
          1: m_day  = wrap_inc(m_day, DMAX);
          2: m_hour = wrap_inc(m_hour, HMAX);
          3: m_tens = wrap_inc(m_tens, 5);
          default: m_ones = wrap_inc(m_ones, 9);
        endcase
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) m_mode = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge Clear);
      if (!Clear) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    logic ld_prev;
    ld_prev = 1'b0;
    forever begin
      @(negedge clk);
      check("cti",     CTI,     model_time());
      check("ld",      LD,      m_ld);
      check("mode",    Mode,    m_mode);
      check("editing", Editing, (m_mode >= 1 && m_mode <= 4));
      check("ld_consecutive", ld_prev & LD, 1'b0);
      ld_prev = LD;
      if (LD) ld_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One button press: held for one cycle, released for one cycle.
  task automatic hit(input bit s, input bit i, input bit c);
    Set_Btn = s; Inc_Btn = i; Cancel_Btn = c;
    @(negedge clk);
    Set_Btn = 0; Inc_Btn = 0; Cancel_Btn = 0;
    @(negedge clk);
  endtask

  initial begin
    int ld_base;
    Clear = 0; Enable = 1; Set_Btn = 0; Inc_Btn = 0; Cancel_Btn = 0; CTO = '0;
    #3;
    check("reset_cti",  CTI,  15'd0);
    check("reset_mode", Mode, 3'd0);
    check("reset_ld",   LD,   1'b0);
    check("reset_edit", Editing, 1'b0);
    @(negedge clk); @(negedge clk);
    Clear = 1;
    @(negedge clk);

    // Capture and full edit/commit walk.
    CTO = 15'b010_01000_100_0011;
    hit(1, 0, 0);
    check("cap_mode", Mode, 3'd1);
    check("cap_edit", Editing, 1'b1);
    check("cap_cti",  CTI, 15'b010_01000_100_0011);
    check("cap_ld",   LD, 1'b0);
    CTO = 15'b000_00000_000_0000;
    hit(0, 1, 0);
    check("day_inc", CTI, 15'b011_01000_100_0011);
    hit(1, 0, 0);
    check("mode_hour", Mode, 3'd2);
    hit(0, 1, 0);
    check("hour_inc", CTI, 15'b011_01001_100_0011);
    hit(1, 0, 0);
    hit(0, 1, 0);
    check("tens_inc", CTI, 15'b011_01001_101_0011);
    hit(1, 0, 0);
    check("mode_mones", Mode, 3'd4);
    for (int k = 0; k < 7; k++) hit(0, 1, 0);
    check("ones_wrap", CTI, 15'b011_01001_101_0000);
    ld_base = ld_count;
    Set_Btn = 1;
    @(negedge clk);
    check("commit_ld",   LD, 1'b1);
    check("commit_mode", Mode, 3'd5);
    check("commit_cti",  CTI, 15'b011_01001_101_0000);
    Set_Btn = 0;
    @(negedge clk);
    check("post_commit_ld",   LD, 1'b0);
    check("post_commit_mode", Mode, 3'd0);
    check("one_ld_pulse", ld_count - ld_base, 1);

    // Wrap of every field at its maximum, no carry.
    CTO = 15'b110_10111_101_1001;
    hit(1, 0, 0);
    hit(0, 1, 0);
    check("wrap_day", CTI, 15'b000_10111_101_1001);
    hit(1, 0, 0); hit(0, 1, 0);
    check("wrap_hour", CTI, 15'b000_00000_101_1001);
    hit(1, 0, 0); hit(0, 1, 0);
    check("wrap_tens", CTI, 15'b000_00000_000_1001);
    hit(1, 0, 0); hit(0, 1, 0);
    check("wrap_ones", CTI, 15'b000_00000_000_0000);
    ld_base = ld_count;
    hit(0, 0, 1);
    check("cancel_mode", Mode, 3'd0);
    check("cancel_cti",  CTI, 15'b000_00000_000_0000);

    // Out-of-range captured hour, then Set+Inc together, then Cancel+Set.
    CTO = 15'b001_11110_010_0101;
    hit(1, 0, 0);
    hit(1, 0, 0);
    hit(0, 1, 0);
    check("hour30_wrap", CTI, 15'b001_00000_010_0101);
    hit(1, 1, 0);
    check("set_inc_mode", Mode, 3'd3);
    check("set_inc_cti",  CTI, 15'b001_00000_010_0101);
    hit(1, 0, 0);
    hit(1, 0, 1);
    check("cancel_set_mode", Mode, 3'd0);
    repeat (20) @(negedge clk);
    check("cancel_no_ld", ld_count - ld_base, 0);

    // Timeout with no presses.
    Set_Btn = 1;
    @(negedge clk);
    Set_Btn = 0;
    repeat (63) @(negedge clk);
    check("timeout_before", Mode, 3'd1);
    @(negedge clk);
    check("timeout_after", Mode, 3'd0);

    // Timeout stretched by 10 Enable-low cycles.
    Set_Btn = 1;
    @(negedge clk);
    Set_Btn = 0;
    repeat (30) @(negedge clk);
    Enable = 0;
    repeat (10) @(negedge clk);
    check("frozen_mode", Mode, 3'd1);
    Enable = 1;
    repeat (33) @(negedge clk);
    check("timeout_en_before", Mode, 3'd1);
    @(negedge clk);
    check("timeout_en_after", Mode, 3'd0);
    check("timeout_no_ld", ld_count - ld_base, 0);

    // Asynchronous Clear mid-edit, with Set held across release.
    CTO = 15'b100_00101_011_0111;
    hit(1, 0, 0); hit(1, 0, 0); hit(1, 0, 0);
    check("pre_clear_mode", Mode, 3'd3);
    #2 Clear = 0;
    #1;
    check("clear_cti",  CTI, 15'd0);
    check("clear_mode", Mode, 3'd0);
    check("clear_ld",   LD, 1'b0);
    check("clear_edit", Editing, 1'b0);
    Set_Btn = 1;
    @(negedge clk);
    Clear = 1;
    repeat (3) @(negedge clk);
    check("held_set_ignored", Mode, 3'd0);
    Set_Btn = 0;
    @(negedge clk);
    Set_Btn = 1;
    @(negedge clk);
    check("repress_mode", Mode, 3'd1);
    check("repress_cti",  CTI, 15'b100_00101_011_0111);
    Set_Btn = 0;
    @(negedge clk);
    hit(0, 0, 1);
    check("final_idle", Mode, 3'd0);
    check("total_ld_pulses", ld_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
